fs_accel_wload: RTL and testbench
=================================

FS_ACCEL_WLOAD -- requirements
Module: fs_accel_wload

Interface
REQ-001 The block SHALL have one parameter: KCNT_W, default 8, meaning the width of the kernel-count input and the kernel-index output.
REQ-002 The block SHALL have the following port: clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have the following port: rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have the following port: wl_start, input, 1 bit, a 1-cycle request to begin loading.
REQ-005 The block SHALL have the following port: wl_kcnt, input, KCNT_W bits, the number of 3x3 kernels to load, sampled when wl_start is accepted.
REQ-006 The block SHALL have the following port: wl_clr, input, 1 bit, a synchronous abort.
REQ-007 The block SHALL have the following port: wl_di, input, 8 bits, a weight byte in row-major order.
REQ-008 The block SHALL have the following ports: wl_di_valid, input, 1 bit, and wl_di_ready, output, 1 bit; together they form the byte-stream handshake.
REQ-009 The block SHALL have the following ports: wl_do_0, wl_do_1 and wl_do_2, output, 8 bits each, the row data for the weight demux inputs di_0..di_2.
REQ-010 The block SHALL have the following port: wl_sel, output, 2 bits, the kernel row select driving the demux select (0..2 only).
REQ-011 The block SHALL have the following port: wl_we, output, 1 bit, a row-write strobe.
REQ-012 The block SHALL have the following port: wl_kidx, output, KCNT_W bits, the index of the kernel currently being loaded.
REQ-013 The block SHALL have the following ports: wl_busy, output, 1 bit, and wl_done, output, 1 bit, a 1-cycle completion pulse.

Function
REQ-014 The block SHALL implement the states IDLE, COLLECT, ISSUE and DONE.
REQ-015 The block SHALL leave IDLE only when wl_start=1: it goes to DONE if wl_kcnt=0, otherwise to COLLECT; in both cases it latches wl_kcnt and clears the byte, row and kernel counters.
REQ-016 The block SHALL ignore wl_start outside IDLE.
REQ-017 In COLLECT, wl_di_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 In COLLECT, a byte SHALL be accepted only on a cycle with wl_di_valid=1 and wl_di_ready=1.
REQ-019 Accepted bytes SHALL be stored in the order byte 0 -> wl_do_0, byte 1 -> wl_do_1, byte 2 -> wl_do_2; each wl_do register SHALL update on the cycle its byte is accepted.
REQ-020 The byte counter SHALL count 0..2; on acceptance of byte 2 it SHALL wrap to 0 and the next state SHALL be ISSUE.
REQ-021 On a cycle with wl_di_valid=0 in COLLECT, the block SHALL change no state; there is no timeout.
REQ-022 In ISSUE, wl_we SHALL be 1 for exactly 1 cycle, with wl_sel equal to the row counter and wl_do_0..2 stable.
REQ-023 The latency SHALL be: wl_we asserts the cycle after byte 2 is accepted.
REQ-024 After ISSUE, the row counter SHALL increment; on wrap from 2 to 0 the kernel counter SHALL increment.
REQ-025 After ISSUE, the next state SHALL be DONE if the row was 2 and the kernel counter equals latched wl_kcnt-1, else COLLECT.
REQ-026 The fastest rate SHALL be one row per 4 cycles (3 accept cycles plus 1 ISSUE cycle).
REQ-027 In DONE, wl_done SHALL be 1 for 1 cycle, and the next state SHALL be IDLE.
REQ-028 wl_busy SHALL be 1 in COLLECT, ISSUE and DONE.
REQ-029 wl_kidx SHALL equal the kernel counter.
REQ-030 wl_kidx SHALL hold its final value (latched wl_kcnt-1, or 0 when wl_kcnt=0) in IDLE until the next accepted wl_start clears it.
REQ-031 wl_sel and wl_do_0..2 SHALL hold their last values outside ISSUE.
REQ-032 wl_sel SHALL never take the value 3.
REQ-033 wl_clr=1 in any state SHALL force IDLE on the next edge: all counters cleared, wl_we=0, wl_done=0, no byte accepted that cycle, and wl_do_0..2 and wl_sel held.
REQ-034 If wl_clr and wl_start are both 1 in IDLE, wl_clr SHALL win and the block SHALL remain in IDLE.
REQ-035 When wl_kcnt is all-ones, the block SHALL load 2^KCNT_W-1 kernels with no counter overflow.

Reset
REQ-036 When rst_n=0, regardless of clk, the block SHALL force IDLE and clear all counters and latched wl_kcnt.
REQ-037 When rst_n=0, all outputs SHALL be 0: wl_do_0..2=0, wl_sel=0, wl_we=0, wl_di_ready=0, wl_kidx=0, wl_busy=0, wl_done=0.
REQ-038 A reset asserted mid-load SHALL abandon the partial row, with no wl_we and no wl_done.
REQ-039 After rst_n deasserts, the block SHALL respond to wl_start no earlier than the first clk edge.

Verification
REQ-040 The bench SHALL cover this scenario: wl_kcnt=1, start, then 9 back-to-back valid bytes 0x01..0x09 -> three wl_we pulses with (sel=0: 01,02,03), (sel=1: 04,05,06), (sel=2: 07,08,09), then wl_done 1 cycle after the last wl_we, and wl_busy=0 afterwards.
REQ-041 The bench SHALL cover this scenario: wl_kcnt=2, 18 bytes with wl_di_valid toggled at random -> 6 wl_we pulses, sel sequence 0,1,2,0,1,2, wl_kidx=0 for the first three pulses and 1 for the last three, and no byte accepted while wl_di_ready=0.
REQ-042 The bench SHALL cover this scenario: wl_kcnt=0 with start -> wl_busy=1 for 1 cycle (DONE), wl_done pulse, and zero wl_we.
REQ-043 The bench SHALL cover this scenario: wl_clr asserted after byte 4 of kernel 0 -> IDLE next edge, no further wl_we, and no wl_done; a following start with wl_kcnt=1 and 9 bytes loads correctly from sel=0.
REQ-044 The bench SHALL cover this scenario: rst_n pulsed low mid-COLLECT, asynchronous to clk -> all outputs read 0 immediately and the partial row is discarded.
REQ-045 The bench SHALL cover this scenario: wl_start pulsed during COLLECT with a different wl_kcnt -> ignored, and the original kernel count completes.

Source files
------------

// File: rtl/fs_accel_wload.sv
// 3x3 kernel weight loader: gathers byte triples from a stream and writes
// them one kernel row at a time into a row-select weight demux.
module fs_accel_wload #(
    parameter int KCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wl_start,
    input  logic [KCNT_W-1:0] wl_kcnt,
    input  logic              wl_clr,
    input  logic [7:0]        wl_di,
    input  logic              wl_di_valid,
    output logic              wl_di_ready,
    output logic [7:0]        wl_do_0,
    output logic [7:0]        wl_do_1,
    output logic [7:0]        wl_do_2,
    output logic [1:0]        wl_sel,
    output logic              wl_we,
    output logic [KCNT_W-1:0] wl_kidx,
    output logic              wl_busy,
    output logic              wl_done
);

    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0][7:0]     row_q;
    logic [1:0]          byte_cnt;
    logic [1:0]          row_cnt;
    logic [1:0]          sel_q;
    logic [KCNT_W-1:0]   kern_cnt;
    logic [KCNT_W-1:0]   kcnt_lat;
    logic                accept;
    logic                last_row;

    assign accept   = (state == COLLECT) && wl_di_valid && !wl_clr;
    // Unreachable with kcnt_lat=0: a zero count jumps straight to DONE.
    assign last_row = (row_cnt == 2'd2) && (kern_cnt == kcnt_lat - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        wl_di_ready = 1'b0;
        wl_we       = 1'b0;
        wl_done     = 1'b0;
        wl_busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (wl_start)
                    state_nxt = (wl_kcnt == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                wl_di_ready = 1'b1;
                if (accept && byte_cnt == 2'd2)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                wl_we     = !wl_clr;
                state_nxt = last_row ? DONE : COLLECT;
            end
            DONE: begin
                wl_done   = !wl_clr;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (wl_clr)
            state_nxt = IDLE;
    end

    // Row data and select only move on accepted bytes, so they hold across
    // abort and idle periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            sel_q    <= '0;
            byte_cnt <= '0;
            row_cnt  <= '0;
            kern_cnt <= '0;
            kcnt_lat <= '0;
        end else if (wl_clr) begin
            byte_cnt <= '0;
            row_cnt  <= '0;
            kern_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wl_start) begin
                        kcnt_lat <= wl_kcnt;
                        byte_cnt <= '0;
                        row_cnt  <= '0;
                        kern_cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        row_q[byte_cnt] <= wl_di;
                        if (byte_cnt == 2'd2) begin
                            byte_cnt <= '0;
                            sel_q    <= row_cnt;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (row_cnt == 2'd2) begin
                        row_cnt <= '0;
                        // Final kernel index is kept for readback after DONE.
                        if (!last_row)
                            kern_cnt <= kern_cnt + 1'b1;
                    end else begin
                        row_cnt <= row_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wl_do_0 = row_q[0];
    assign wl_do_1 = row_q[1];
    assign wl_do_2 = row_q[2];
    assign wl_sel  = sel_q;
    assign wl_kidx = kern_cnt;

endmodule

// File: tb/tb_fs_accel_wload.sv
// Directed bench for fs_accel_wload: a monitor records every row write and
// completion pulse; scenarios compare them against hand-derived rows.
module tb_fs_accel_wload;

    localparam int KCNT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wl_start;
    logic [KCNT_W-1:0] wl_kcnt;
    logic              wl_clr;
    logic [7:0]        wl_di;
    logic              wl_di_valid;
    logic              wl_di_ready;
    logic [7:0]        wl_do_0, wl_do_1, wl_do_2;
    logic [1:0]        wl_sel;
    logic              wl_we;
    logic [KCNT_W-1:0] wl_kidx;
    logic              wl_busy;
    logic              wl_done;

    fs_accel_wload #(.KCNT_W(KCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .wl_start(wl_start), .wl_kcnt(wl_kcnt),
        .wl_clr(wl_clr), .wl_di(wl_di), .wl_di_valid(wl_di_valid),
        .wl_di_ready(wl_di_ready), .wl_do_0(wl_do_0), .wl_do_1(wl_do_1),
        .wl_do_2(wl_do_2), .wl_sel(wl_sel), .wl_we(wl_we), .wl_kidx(wl_kidx),
        .wl_busy(wl_busy), .wl_done(wl_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        sel;
        logic [7:0]        d0, d1, d2;
        logic [KCNT_W-1:0] kidx;
        int                cyc;
    } wr_t;

    wr_t wr_q[$];
    int  done_cnt  = 0;
    int  done_cyc  = 0;
    int  cyc       = 0;
    int  n_cmp     = 0;
    int  n_bad     = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && wl_we) begin
            wr_q.push_back('{sel: wl_sel, d0: wl_do_0, d1: wl_do_1, d2: wl_do_2,
                             kidx: wl_kidx, cyc: cyc});
            chk("sel_range", {63'd0, wl_sel != 2'd3}, 64'd1);
        end
        if (rst_n && wl_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic start(input logic [KCNT_W-1:0] k);
        wl_kcnt  = k;
        wl_start = 1'b1;
        @(posedge clk); #1;
        wl_start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                wl_di = 8'hEE; wl_di_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        wl_di = b; wl_di_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wl_di_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", {63'd0, wl_di_ready}, 64'd1);
        @(posedge clk); #1;
        wl_di_valid = 1'b0;
        wl_di = 8'hEE;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_wait", done_cnt, target);
    endtask

    task automatic chk_rows(input string tag, input int nrows, input logic [7:0] base);
        wr_t e;
        logic [7:0] b;
        chk({tag, "_nwr"}, wr_q.size(), nrows);
        for (int r = 0; r < nrows && r < wr_q.size(); r++) begin
            e = wr_q[r];
            b = base + 8'(3 * r);
            chk({tag, "_sel"},  e.sel,  r % 3);
            chk({tag, "_kidx"}, e.kidx, r / 3);
            chk({tag, "_row"},  {e.d0, e.d1, e.d2}, {b, b + 8'd1, b + 8'd2});
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; wl_start = 1'b0; wl_kcnt = '0; wl_clr = 1'b0;
        wl_di = 8'h00; wl_di_valid = 1'b0;
        #12;
        chk("reset_outs", {wl_do_0, wl_do_1, wl_do_2, wl_sel, wl_we, wl_di_ready,
                           wl_kidx, wl_busy, wl_done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // One kernel, back-to-back bytes 01..09.
        clear_log();
        start(8'd1);
        for (int i = 0; i < 9; i++) push(8'(i + 1), 1'b0);
        wait_done(1);
        chk_rows("k1", 3, 8'h01);
        if (wr_q.size() == 3) chk("k1_done_lat", done_cyc, wr_q[2].cyc + 1);
        if (wr_q.size() == 3) chk("k1_row_rate", wr_q[1].cyc - wr_q[0].cyc, 4);
        @(negedge clk);
        chk("k1_busy_after", wl_busy, 1'b0);
        chk("k1_kidx_hold", wl_kidx, 8'd0);
        @(posedge clk); #1;

        // Two kernels with random valid gaps.
        clear_log();
        start(8'd2);
        for (int i = 0; i < 18; i++) push(8'h20 + 8'(i), 1'b1);
        wait_done(1);
        chk_rows("k2", 6, 8'h20);
        @(negedge clk);
        chk("k2_kidx_hold", wl_kidx, 8'd1);
        @(posedge clk); #1;

        // Zero kernels: straight through DONE.
        clear_log();
        start(8'd0);
        @(negedge clk);
        chk("k0_busy", wl_busy, 1'b1);
        chk("k0_done", wl_done, 1'b1);
        @(negedge clk);
        chk("k0_idle", wl_busy, 1'b0);
        @(posedge clk); #1;
        chk("k0_nwr", wr_q.size(), 0);
        chk("k0_ndone", done_cnt, 1);

        // Abort after byte index 4 of kernel 0, then a clean reload.
        clear_log();
        start(8'd1);
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 1'b0);
        wl_clr = 1'b1;
        @(posedge clk); #1;
        wl_clr = 1'b0;
        @(negedge clk);
        chk("clr_busy", wl_busy, 1'b0);
        chk("clr_do_hold", {wl_do_0, wl_do_1, wl_sel}, {8'h43, 8'h44, 2'd0});
        repeat (10) @(posedge clk); #1;
        chk("clr_nwr", wr_q.size(), 1);
        chk("clr_ndone", done_cnt, 0);
        wl_clr = 1'b1; wl_kcnt = 8'd1; wl_start = 1'b1;
        @(posedge clk); #1;
        wl_clr = 1'b0; wl_start = 1'b0;
        @(negedge clk);
        chk("clr_beats_start", wl_busy, 1'b0);
        @(posedge clk); #1;
        clear_log();
        start(8'd1);
        for (int i = 0; i < 9; i++) push(8'h50 + 8'(i), 1'b0);
        wait_done(1);
        chk_rows("reload", 3, 8'h50);

        // Asynchronous reset mid-collect.
        clear_log();
        start(8'd1);
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_outs", {wl_do_0, wl_do_1, wl_do_2, wl_sel, wl_we, wl_di_ready,
                          wl_kidx, wl_busy, wl_done}, 64'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk); #1;
        chk("arst_nwr", wr_q.size(), 1);
        chk("arst_ndone", done_cnt, 0);
        chk("arst_idle", wl_busy, 1'b0);

        // Start during COLLECT is ignored.
        clear_log();
        start(8'd1);
        for (int i = 0; i < 2; i++) push(8'h70 + 8'(i), 1'b0);
        start(8'd3);
        for (int i = 2; i < 9; i++) push(8'h70 + 8'(i), 1'b0);
        wait_done(1);
        chk_rows("ign_start", 3, 8'h70);
        repeat (20) @(posedge clk); #1;
        chk("ign_nwr_final", wr_q.size(), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
